llr_demux: RTL and testbench
============================

LLR_DEMUX -- requirements
Module: llr_demux

Interface
REQ-001 SHALL have parameter LLR_W, default 5, LLR bit width.
REQ-002 SHALL have parameter LLR_N, default 8, LLRs per parallel word; LLR_N SHALL be a power of two.
REQ-003 SHALL have port clk_h  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ival  input  1  parallel word valid.
REQ-006 SHALL have port isop / ieop / ieof  input  1 each  start-of-packet / end-of-packet / end-of-frame tags of the word.
REQ-007 SHALL have port ibit  input  LLR_W x [0:LLR_N-1]  parallel LLR word; element 0 is sent first.
REQ-008 SHALL have port ordy  output  1  block can accept a word this cycle.
REQ-009 SHALL have port irdy  input  1  downstream accepts the serial element this cycle.
REQ-010 SHALL have port oval  output  1  serial element valid.
REQ-011 SHALL have port osop / oeop / oeof  output  1 each  serial framing tags.
REQ-012 SHALL have port obit  output  LLR_W  serial LLR element.

Function
REQ-013 Word accept SHALL occur when ival=1 and ordy=1; ival while ordy=0 SHALL be ignored, and upstream holds the word.
REQ-014 Serial transfer SHALL occur when oval=1 and irdy=1; while irdy=0, obit, oval and the tags SHALL hold stable.
REQ-015 FSM states SHALL be IDLE and SHIFT, with element index idx of log2(LLR_N) bits.
REQ-016 IDLE -> SHIFT on accept: the word is latched and idx is set to 0; oval=1 with element 0 the next cycle, giving 1-cycle latency.
REQ-017 In SHIFT, each transfer SHALL increment idx; obit SHALL equal ibit[idx] of the latched word.
REQ-018 On the transfer at idx=LLR_N-1 with no pending word, the FSM SHALL return to IDLE, idx SHALL wrap to 0, and oval SHALL be 0 the next cycle.
REQ-019 osop SHALL equal the latched isop only while idx=0; oeop and oeof SHALL equal the latched ieop and ieof only while idx=LLR_N-1; all tags SHALL be 0 otherwise.
REQ-020 When oval=0, obit and all tags SHALL be 0.
REQ-021 With irdy held high, one word SHALL take exactly LLR_N consecutive oval cycles.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: state IDLE, idx 0, oval/osop/oeop/oeof 0, obit 0, latched word and tags 0, hold buffer empty.
REQ-023 Reset asserted mid-word SHALL discard the word with no partial completion; the first cycle after release SHALL have oval=0 and ordy=1.

Configuration
REQ-024 Macro LLR_DEMUX_BUF_EN SHALL select buffering.
REQ-025 Without LLR_DEMUX_BUF_EN: ordy = (state==IDLE) | (state==SHIFT & idx==LLR_N-1 & irdy), a combinational path from irdy. A word accepted on the last-element transfer SHALL start at element 0 the next cycle with no bubble.
REQ-026 With LLR_DEMUX_BUF_EN: a one-word hold register SHALL be present and ordy SHALL equal !hold_full (registered, no irdy path).
REQ-027 With LLR_DEMUX_BUF_EN: a word accepted in IDLE SHALL go directly to the shift register; a word accepted in SHIFT SHALL go to the hold register.
REQ-028 With LLR_DEMUX_BUF_EN: on the last-element transfer, the hold word SHALL move to shift with no bubble.
REQ-029 With LLR_DEMUX_BUF_EN: if the hold register empties and a new word is accepted in the same cycle, the new word SHALL occupy hold.

Structure
REQ-030 Package llr_pkg SHALL hold LLR_W and LLR_N defaults, typedef llr_t (logic [LLR_W-1:0]) and the FSM state enum; the serializing collector of the same codec SHALL import it.
REQ-031 No sub-module is required; the hold register SHALL be inline under the macro.

Verification
REQ-032 Single word: ibit={1..8}, isop=ieop=ieof=1, irdy=1 -> oval cycles 1..8 carry obit 1..8; osop=1 on cycle 1 only; oeop=oeof=1 on cycle 8 only.
REQ-033 Back-to-back words A={1..8} and B={9..16}, ival held high, irdy=1 -> 16 contiguous oval cycles carrying 1..16 in both macro configurations.
REQ-034 Stall: irdy=0 during element 3 for 4 cycles -> obit=3 held for 5 cycles; then 4..8 follow; ordy stays 0 without the macro.
REQ-035 Ignored input: ival=1 with ordy=0 and word {31,...} -> no effect on the serial stream.
REQ-036 Reset mid-word: rst_n low at element 5 -> outputs 0 immediately; after release, oval=0 and ordy=1; the next word starts at element 0.
REQ-037 BUF_EN: three words offered back-to-back -> the third is accepted only after the first word's last transfer; the stream is gap-free.

Source files
------------

// File: rtl/llr_pkg.sv
// Shared definitions for the LLR demultiplexer and the serializing collector of the same codec.
package llr_pkg;

    localparam int LLR_W_DEF = 5;
    localparam int LLR_N_DEF = 8;

    typedef logic [LLR_W_DEF-1:0] llr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/llr_demux.sv
// Parallel-to-serial LLR demultiplexer: one LLR_N-wide word in, LLR_N serial elements out.
// Define LLR_DEMUX_BUF_EN to add a one-word hold register that removes the irdy->ordy path.
module llr_demux #(
    parameter int LLR_W = llr_pkg::LLR_W_DEF,
    parameter int LLR_N = llr_pkg::LLR_N_DEF
) (
    input  logic             clk_h,
    input  logic             rst_n,
    input  logic             ival,
    input  logic             isop,
    input  logic             ieop,
    input  logic             ieof,
    input  logic [LLR_W-1:0] ibit [0:LLR_N-1],
    output logic             ordy,
    input  logic             irdy,
    output logic             oval,
    output logic             osop,
    output logic             oeop,
    output logic             oeof,
    output logic [LLR_W-1:0] obit
);
    import llr_pkg::*;

    localparam int IDX_W = (LLR_N > 1) ? $clog2(LLR_N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LLR_N - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [LLR_W-1:0] word [0:LLR_N-1];
    logic             sop_q, eop_q, eof_q;
    logic             last, xfer, accept, load, take_hold;

    assign last   = (state == SHIFT) && (idx == IDX_LAST);
    assign xfer   = (state == SHIFT) && irdy;
    assign accept = ival && ordy;

`ifdef LLR_DEMUX_BUF_EN
    logic [LLR_W-1:0] hold [0:LLR_N-1];
    logic             hold_full, hold_sop, hold_eop, hold_eof;
    logic             to_hold;

    assign ordy      = !hold_full;
    assign take_hold = xfer && last && hold_full;
    // An empty hold at the last transfer lets a fresh word bypass straight into the shifter.
    assign load      = accept && ((state == IDLE) || (xfer && last));
    assign to_hold   = accept && !load;

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_sop  <= 1'b0;
            hold_eop  <= 1'b0;
            hold_eof  <= 1'b0;
            for (int i = 0; i < LLR_N; i++) hold[i] <= '0;
        end else begin
            if (to_hold) begin
                hold_full <= 1'b1;
                hold_sop  <= isop;
                hold_eop  <= ieop;
                hold_eof  <= ieof;
                hold      <= ibit;
            end else if (take_hold) begin
                hold_full <= 1'b0;
            end
        end
    end
`else
    assign ordy      = (state == IDLE) || (last && irdy);
    assign load      = accept;
    assign take_hold = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (load || take_hold) begin
            state_nxt = SHIFT;
            idx_nxt   = '0;
        end else if (xfer) begin
            if (last) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            eof_q <= 1'b0;
            for (int i = 0; i < LLR_N; i++) word[i] <= '0;
        end else if (load) begin
            sop_q <= isop;
            eop_q <= ieop;
            eof_q <= ieof;
            word  <= ibit;
`ifdef LLR_DEMUX_BUF_EN
        end else if (take_hold) begin
            sop_q <= hold_sop;
            eop_q <= hold_eop;
            eof_q <= hold_eof;
            word  <= hold;
`endif
        end
    end

    // Outputs are pure decodes of the registered state, so they hold while irdy is low.
    assign oval = (state == SHIFT);
    assign obit = oval ? word[idx] : '0;
    assign osop = oval && (idx == '0) && sop_q;
    assign oeop = last && eop_q;
    assign oeof = last && eof_q;

endmodule

// File: tb/tb_llr_demux.sv
// Scoreboard bench for llr_demux; honours LLR_DEMUX_BUF_EN when compiled with it.
module tb_llr_demux;
    import llr_pkg::*;

    localparam int W  = LLR_W_DEF;
    localparam int N  = LLR_N_DEF;
    localparam int EW = W + 3;

    logic         clk_h = 1'b0;
    logic         rst_n = 1'b0;
    logic         ival = 1'b0, isop = 1'b0, ieop = 1'b0, ieof = 1'b0, irdy = 1'b0;
    logic [W-1:0] ibit [0:N-1];
    logic         ordy, oval, osop, oeop, oeof;
    logic [W-1:0] obit;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           gaps = 0;
    int           last_xfer = 0;
    logic         prev_oval = 1'b0;
    logic [EW-1:0] sb [$];
    logic [EW-1:0] exp_e;

    llr_demux #(.LLR_W(W), .LLR_N(N)) dut (
        .clk_h(clk_h), .rst_n(rst_n), .ival(ival), .isop(isop), .ieop(ieop), .ieof(ieof),
        .ibit(ibit), .ordy(ordy), .irdy(irdy), .oval(oval), .osop(osop), .oeop(oeop),
        .oeof(oeof), .obit(obit)
    );

    always #5 clk_h = ~clk_h;

    always @(posedge clk_h) cyc <= cyc + 1;

    // Stream monitor: every transfer must match the scoreboard head; idle outputs must be zero.
    always @(negedge clk_h) begin
        #3;
        if (oval) begin
            if (irdy) begin
                checks++;
                last_xfer = cyc + 1;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got obit=%0d sop=%b eop=%b eof=%b, want no element",
                             obit, osop, oeop, oeof);
                end else begin
                    exp_e = sb.pop_front();
                    if ({obit, osop, oeop, oeof} !== exp_e) begin
                        errors++;
                        $display("FAIL stream: got obit=%0d sop=%b eop=%b eof=%b, want obit=%0d sop=%b eop=%b eof=%b",
                                 obit, osop, oeop, oeof, exp_e[EW-1:3], exp_e[2], exp_e[1], exp_e[0]);
                    end
                end
            end
        end else begin
            checks++;
            if ({obit, osop, oeop, oeof} !== '0) begin
                errors++;
                $display("FAIL idle_zero: got obit=%0d sop=%b eop=%b eof=%b, want all 0",
                         obit, osop, oeop, oeof);
            end
            if (prev_oval && sb.size() > 0) gaps++;
        end
        prev_oval = oval;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Offers one word (element i = base + i*step) until accepted; starts and ends on a negedge.
    task automatic send(input int base, input int step, input logic s, input logic e,
                        input logic f, output int acc_cyc);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        acc_cyc = -1;
        ival = 1'b1;
        isop = s;
        ieop = e;
        ieof = f;
        for (int i = 0; i < N; i++) ibit[i] = W'(base + i * step);
        while (!acc && n < 100) begin
            #1;
            if (ordy) begin
                acc = 1'b1;
                acc_cyc = cyc + 1;
                for (int i = 0; i < N; i++)
                    sb.push_back({W'(base + i * step), (s && i == 0), (e && i == N - 1), (f && i == N - 1)});
            end
            @(negedge clk_h);
            n++;
        end
        ival = 1'b0;
        isop = 1'b0;
        ieop = 1'b0;
        ieof = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: word base %0d not accepted in %0d cycles, want accepted", base, n);
        end
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk_h);
            n++;
        end
        ok = (sb.size() == 0);
        @(negedge clk_h);
    endtask

    task automatic test_reset();
        irdy = 1'b1;
        for (int i = 0; i < N; i++) ibit[i] = '0;
        repeat (2) @(negedge clk_h);
        #1;
        checks++;
        if (oval !== 1'b0 || obit !== '0 || osop !== 1'b0 || oeop !== 1'b0 || oeof !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got oval=%b obit=%0d, want oval=0 obit=0", oval, obit);
        end
        @(negedge clk_h);
        rst_n = 1'b1;
        #1;
        checks++;
        if (oval !== 1'b0 || ordy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got oval=%b ordy=%b, want oval=0 ordy=1", oval, ordy);
        end
        @(negedge clk_h);
    endtask

    task automatic test_single_word();
        int a;
        bit ok;
        gaps = 0;
        send(1, 1, 1'b1, 1'b1, 1'b1, a);
        #1;
        checks++;
        if (oval !== 1'b1 || obit !== W'(1) || osop !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got oval=%b obit=%0d sop=%b, want oval=1 obit=1 sop=1", oval, obit, osop);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: got %0d pending, want 0", sb.size());
        end
        checks++;
        if (last_xfer - a !== N || gaps !== 0) begin
            errors++;
            $display("FAIL single_span: got %0d cycles gaps=%0d, want %0d cycles gaps=0", last_xfer - a, gaps, N);
        end
    endtask

    task automatic test_back_to_back();
        int a, b, want_b;
        bit ok;
        gaps = 0;
`ifdef LLR_DEMUX_BUF_EN
        want_b = 1;
`else
        want_b = N;
`endif
        send(1, 1, 1'b1, 1'b0, 1'b0, a);
        send(9, 1, 1'b0, 1'b1, 1'b1, b);
        drain(ok);
        checks++;
        if (!ok || gaps !== 0) begin
            errors++;
            $display("FAIL b2b_stream: got pending=%0d gaps=%0d, want 0 and 0", sb.size(), gaps);
        end
        checks++;
        if (b - a !== want_b) begin
            errors++;
            $display("FAIL b2b_accept: got second accept after %0d cycles, want %0d", b - a, want_b);
        end
        checks++;
        if (last_xfer - a !== 2 * N) begin
            errors++;
            $display("FAIL b2b_span: got %0d cycles, want %0d", last_xfer - a, 2 * N);
        end
    endtask

    task automatic test_stall();
        int a, n;
        bit ok;
        gaps = 0;
        send(1, 1, 1'b1, 1'b1, 1'b1, a);
        n = 0;
        #1;
        while (!(oval === 1'b1 && obit === W'(3)) && n < 20) begin
            @(negedge clk_h);
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL stall_reach: element 3 never shown, got obit=%0d, want 3", obit);
        end
        irdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifndef LLR_DEMUX_BUF_EN
            checks++;
            if (ordy !== 1'b0) begin
                errors++;
                $display("FAIL stall_ordy: got ordy=%b at stall cycle %0d, want 0", ordy, k);
            end
`endif
            @(negedge clk_h);
            #1;
            if (k == 3) irdy = 1'b1;
            checks++;
            if (oval !== 1'b1 || obit !== W'(3) || osop !== 1'b0 || oeop !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got oval=%b obit=%0d at hold cycle %0d, want oval=1 obit=3", oval, obit, k + 1);
            end
        end
        @(negedge clk_h);
        drain(ok);
        checks++;
        if (!ok || last_xfer - a !== N + 4) begin
            errors++;
            $display("FAIL stall_span: got %0d cycles pending=%0d, want %0d cycles pending=0",
                     last_xfer - a, sb.size(), N + 4);
        end
    endtask

    task automatic test_ignored_input();
        int a, b;
        bit ok;
        send(1, 1, 1'b1, 1'b1, 1'b1, a);
        send(9, 1, 1'b1, 1'b1, 1'b1, b);
        ival = 1'b1;
        isop = 1'b1;
        ieop = 1'b1;
        ieof = 1'b1;
        for (int i = 0; i < N; i++) ibit[i] = W'(31);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ordy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_ordy: got ordy=%b at cycle %0d, want 0", ordy, k);
            end
            @(negedge clk_h);
        end
        ival = 1'b0;
        isop = 1'b0;
        ieop = 1'b0;
        ieof = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore_drain: got %0d pending, want 0", sb.size());
        end
    endtask

    task automatic test_three_words();
        int a, b, c, want_c;
        bit ok;
        gaps = 0;
`ifdef LLR_DEMUX_BUF_EN
        want_c = N + 1;
`else
        want_c = 2 * N;
`endif
        send(1, 1, 1'b1, 1'b1, 1'b0, a);
        send(9, 1, 1'b1, 1'b1, 1'b0, b);
        send(17, 1, 1'b1, 1'b1, 1'b1, c);
        drain(ok);
        checks++;
        if (c - a !== want_c) begin
            errors++;
            $display("FAIL three_accept: got third accept after %0d cycles, want %0d", c - a, want_c);
        end
        checks++;
        if (!ok || gaps !== 0 || last_xfer - a !== 3 * N) begin
            errors++;
            $display("FAIL three_stream: got span=%0d gaps=%0d pending=%0d, want span=%0d gaps=0 pending=0",
                     last_xfer - a, gaps, sb.size(), 3 * N);
        end
    endtask

    task automatic test_reset_mid_word();
        int a, n;
        bit ok;
        send(1, 1, 1'b1, 1'b1, 1'b1, a);
        n = 0;
        #1;
        while (!(oval === 1'b1 && obit === W'(5)) && n < 20) begin
            @(negedge clk_h);
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL rstmid_reach: element 5 never shown, got obit=%0d, want 5", obit);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (oval !== 1'b0 || obit !== '0 || osop !== 1'b0 || oeop !== 1'b0 || oeof !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got oval=%b obit=%0d, want oval=0 obit=0", oval, obit);
        end
        @(negedge clk_h);
        rst_n = 1'b1;
        #1;
        checks++;
        if (oval !== 1'b0 || ordy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release: got oval=%b ordy=%b, want oval=0 ordy=1", oval, ordy);
        end
        @(negedge clk_h);
        send(9, 2, 1'b1, 1'b0, 1'b1, a);
        #1;
        checks++;
        if (oval !== 1'b1 || obit !== W'(9) || osop !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: got oval=%b obit=%0d sop=%b, want oval=1 obit=9 sop=1", oval, obit, osop);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_drain: got %0d pending, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_ignored_input();
        test_three_words();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
